// File: rtl/uart_rx_engine.sv
// -----------------------------------------------------------------------------
// uart_rx_engine
//
// UART receive engine. It detects the start bit on an oversampled tick,
// samples each bit at its midpoint, and supports:
//   - a configurable payload width,
//   - parity selected at run time (none / even / odd),
//   - one or two stop bits.
// The received word is presented on a registered valid/ready output together
// with its parity and framing status. A finished frame that cannot be handed
// over, because the previous word is still held, is dropped and reported on
// overrun_err.
//
// Parameters
//   DATA_BITS   payload bits per frame (5..9)
//   OVERSAMPLE  sample_tick pulses per bit period (even, 4..64)
//   STOP_BITS   stop bits checked per frame (1 or 2)
//
// Ports
//   clk          clock
//   nrst         synchronous active-low reset
//   sample_tick  one-cycle strobe at OVERSAMPLE x baud rate
//   rx_i         serial line, already synchronised to clk, idle high
//   parity_mode  00 none, 01 even, 10 odd, 11 none (latched at start bit)
//   rx_data      received payload, LSB first on the line
//   rx_valid     rx_data / parity_err / frame_err are valid
//   rx_ready     consumer accepts the word when rx_valid && rx_ready
//   parity_err   parity mismatch for the held word
//   frame_err    a stop bit of the held word was sampled low
//   overrun_err  one-cycle pulse: a completed frame was dropped
//   busy         high whenever a frame is being received
// -----------------------------------------------------------------------------
module uart_rx_engine #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 sample_tick,
    input  logic                 rx_i,
    input  logic [1:0]           parity_mode,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [CW-1:0]          cnt_r;
    logic [3:0]             bit_cnt_r;
    logic                   stop_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   xor_r;
    logic [1:0]             mode_r;
    logic                   par_err_r;
    logic                   ferr_acc_r;

    logic [CW-1:0]          limit_s;
    logic                   at_limit_s;
    logic                   sample_s;
    logic                   start_det_s;
    logic                   par_en_s;
    logic                   complete_s;
    logic                   load_s;
    logic                   overrun_s;
    logic                   accept_s;

    // Parity error for one frame: even mode flags an odd total of ones, odd
    // mode flags an even total (data XOR combined with the parity bit).
    function automatic logic parity_error_f(input logic data_xor,
                                            input logic par_bit,
                                            input logic odd_mode);
        logic total_s;
        total_s = data_xor ^ par_bit;
        return odd_mode ? ~total_s : total_s;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Per-cycle decode: sampling point, start detection and completion.
    always_comb begin
        limit_s     = FULL_M1;
        sample_s    = 1'b0;
        start_det_s = 1'b0;
        complete_s  = 1'b0;
        // The start bit is sampled after half a bit period, every other bit
        // after a full one, so each later sample lands mid-bit.
        if (state_r == ST_START) begin
            limit_s = HALF_M1;
        end else begin
            limit_s = FULL_M1;
        end
        at_limit_s = (cnt_r == limit_s);
        if (state_r == ST_IDLE) begin
            start_det_s = sample_tick & ~rx_i;
            sample_s    = 1'b0;
        end else begin
            start_det_s = 1'b0;
            sample_s    = sample_tick & at_limit_s;
        end
        if ((state_r == ST_STOP) && sample_s && (stop_cnt_r == STOP_LAST)) begin
            complete_s = 1'b1;
        end else begin
            complete_s = 1'b0;
        end
        par_en_s  = (mode_r == 2'b01) || (mode_r == 2'b10);
        accept_s  = rx_valid & rx_ready;
        load_s    = complete_s & (~rx_valid | rx_ready);
        overrun_s = complete_s & rx_valid & ~rx_ready;
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_det_s) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_s) begin
                    // A high line at mid start bit was only a glitch.
                    if (rx_i) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_s && (bit_cnt_r == LAST_BIT)) begin
                    if (par_en_s) begin
                        next_state_s = ST_PARITY;
                    end else begin
                        next_state_s = ST_STOP;
                    end
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (sample_s) begin
                    next_state_s = ST_STOP;
                end else begin
                    next_state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (complete_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Oversample counter: restarts at start detection and at every bit sample.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_r <= CNT_ZERO;
        end else if (start_det_s) begin
            cnt_r <= CNT_ZERO;
        end else if ((state_r != ST_IDLE) && sample_tick) begin
            cnt_r <= at_limit_s ? CNT_ZERO : (cnt_r + CNT_ONE);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Data-bit and stop-bit counters, only running in their own states.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            bit_cnt_r  <= 4'd0;
            stop_cnt_r <= 1'b0;
        end else begin
            if (state_r != ST_DATA) begin
                bit_cnt_r <= 4'd0;
            end else if (sample_s) begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (state_r != ST_STOP) begin
                stop_cnt_r <= 1'b0;
            end else if (sample_s) begin
                stop_cnt_r <= ~stop_cnt_r;
            end else begin
                stop_cnt_r <= stop_cnt_r;
            end
        end
    end

    // Frame datapath: shift register, running XOR, latched mode, error flags.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            shift_r    <= {DATA_BITS{1'b0}};
            xor_r      <= 1'b0;
            mode_r     <= 2'b00;
            par_err_r  <= 1'b0;
            ferr_acc_r <= 1'b0;
        end else if (start_det_s) begin
            // Mode is frozen for the whole frame from here on.
            xor_r      <= 1'b0;
            mode_r     <= parity_mode;
            par_err_r  <= 1'b0;
            ferr_acc_r <= 1'b0;
        end else if (sample_s && (state_r == ST_DATA)) begin
            // LSB arrives first, so bits enter at the top and move down.
            shift_r <= {rx_i, shift_r[DATA_BITS-1:1]};
            xor_r   <= xor_r ^ rx_i;
        end else if (sample_s && (state_r == ST_PARITY)) begin
            par_err_r <= parity_error_f(xor_r, rx_i, mode_r == 2'b10);
        end else if (sample_s && (state_r == ST_STOP)) begin
            ferr_acc_r <= ferr_acc_r | ~rx_i;
        end else begin
            shift_r    <= shift_r;
        end
    end

    // Registered output word, handshake and status.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rx_data     <= {DATA_BITS{1'b0}};
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            overrun_err <= overrun_s;
            busy        <= (next_state_s != ST_IDLE);
            if (load_s) begin
                // The last stop sample is folded in directly.
                rx_data    <= shift_r;
                parity_err <= par_err_r;
                frame_err  <= ferr_acc_r | ~rx_i;
                rx_valid   <= 1'b1;
            end else if (accept_s) begin
                rx_valid   <= 1'b0;
            end else begin
                rx_valid   <= rx_valid;
            end
        end
    end

endmodule
